// File: rtl/lisa_qspi_dma.sv
// Block-copy engine on one QSPI arbiter port: read burst into a local buffer, write it back out, repeat.
// Optional LISA_QSPI_DMA_FILL_EN adds a fill mode that skips reads and writes a constant pattern.
module lisa_qspi_dma #(
    parameter int CHIP_SELECTS = 2,
    parameter int BURST_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [23:0]             src_addr,
    input  logic [23:0]             dst_addr,
    input  logic [CHIP_SELECTS-1:0] src_ce,
    input  logic [CHIP_SELECTS-1:0] dst_ce,
    input  logic [11:0]             word_count,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [23:0]             addr,
    input  logic [15:0]             rdata,
    output logic [15:0]             wdata,
    output logic [1:0]              wstrb,
    input  logic                    ready,
    input  logic                    xfer_done,
    output logic                    valid,
    output logic [3:0]              xfer_len,
`ifdef LISA_QSPI_DMA_FILL_EN
    input  logic                    fill_mode,
    input  logic [15:0]             fill_data,
`endif
    output logic [CHIP_SELECTS-1:0] ce_ctrl
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [3:0] BL = 4'(BURST_LEN);
    localparam int         PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    function automatic logic [3:0] burst_of(input logic [11:0] n);
        return (n > {8'd0, BL}) ? BL : n[3:0];
    endfunction

    state_t                  state;
    logic [23:0]             cur_src;
    logic [23:0]             cur_dst;
    logic [CHIP_SELECTS-1:0] src_ce_q;
    logic [CHIP_SELECTS-1:0] dst_ce_q;
    logic [11:0]             remaining;
    logic [3:0]              wr_ptr;
    logic [3:0]              rd_ptr;
    logic                    abort_pend;
    logic                    fill_q;
    logic                    start_fill;
    logic                    cap;
    logic [15:0]             mem [0:(1<<PW)-1];

`ifdef LISA_QSPI_DMA_FILL_EN
    assign start_fill = fill_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fill_q <= 1'b0;
        else if (state == IDLE && start)
            fill_q <= fill_mode;
    end
`else
    assign start_fill = 1'b0;
    assign fill_q     = 1'b0;
`endif

    // Words beyond the burst length are dropped so the buffer can never be overrun.
    assign cap = (state == RD) && valid && ready && (wr_ptr < xfer_len);

    always_ff @(posedge clk) begin
        if (cap)
            mem[wr_ptr[PW-1:0]] <= rdata;
    end

    always_comb begin
        wdata = '0;
        if (state == WR) begin
`ifdef LISA_QSPI_DMA_FILL_EN
            if (fill_q)
                wdata = fill_data;
            else if (rd_ptr < xfer_len)
                wdata = mem[rd_ptr[PW-1:0]];
`else
            if (rd_ptr < xfer_len)
                wdata = mem[rd_ptr[PW-1:0]];
`endif
        end
    end

    // In RD/WR, valid=0 is the one-cycle re-arbitration gap; the next cycle raises the new burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            valid      <= 1'b0;
            addr       <= '0;
            wstrb      <= '0;
            xfer_len   <= '0;
            ce_ctrl    <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            src_ce_q   <= '0;
            dst_ce_q   <= '0;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            abort_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && abort)
                abort_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_src    <= src_addr;
                        cur_dst    <= dst_addr;
                        src_ce_q   <= src_ce;
                        dst_ce_q   <= dst_ce;
                        remaining  <= word_count;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        if (word_count == 12'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            busy     <= 1'b1;
                            valid    <= 1'b1;
                            xfer_len <= burst_of(word_count);
                            if (start_fill) begin
                                state   <= WR;
                                addr    <= dst_addr;
                                ce_ctrl <= dst_ce;
                                wstrb   <= 2'b11;
                            end else begin
                                state   <= RD;
                                addr    <= src_addr;
                                ce_ctrl <= src_ce;
                                wstrb   <= 2'b00;
                            end
                        end
                    end
                end
                RD: begin
                    if (!valid) begin
                        valid    <= 1'b1;
                        addr     <= cur_src;
                        ce_ctrl  <= src_ce_q;
                        wstrb    <= 2'b00;
                        xfer_len <= burst_of(remaining);
                    end else begin
                        if (cap)
                            wr_ptr <= wr_ptr + 4'd1;
                        if (xfer_done) begin
                            valid  <= 1'b0;
                            wr_ptr <= '0;
                            state  <= WR;
                        end
                    end
                end
                WR: begin
                    if (!valid) begin
                        valid    <= 1'b1;
                        addr     <= cur_dst;
                        ce_ctrl  <= dst_ce_q;
                        wstrb    <= 2'b11;
                        xfer_len <= burst_of(remaining);
                    end else begin
                        if (ready && rd_ptr < xfer_len)
                            rd_ptr <= rd_ptr + 4'd1;
                        if (xfer_done) begin
                            valid     <= 1'b0;
                            rd_ptr    <= '0;
                            cur_src   <= cur_src + {19'd0, xfer_len, 1'b0};
                            cur_dst   <= cur_dst + {19'd0, xfer_len, 1'b0};
                            remaining <= remaining - {8'd0, xfer_len};
                            if (remaining == {8'd0, xfer_len} || abort_pend || abort) begin
                                state      <= FIN;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                aborted    <= abort_pend || abort;
                                abort_pend <= 1'b0;
                            end else begin
                                state <= fill_q ? WR : RD;
                            end
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisa_qspi_dma.sv
// Randomized scoreboard bench for lisa_qspi_dma: a QSPI slave model serves bursts and checks
// each burst header and write word against queues filled by a chunk-level reference model.
module tb_lisa_qspi_dma;
    localparam int CS = 2;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [23:0]   src_addr = '0;
    logic [23:0]   dst_addr = '0;
    logic [CS-1:0] src_ce = '0;
    logic [CS-1:0] dst_ce = '0;
    logic [11:0]   word_count = '0;
    logic          busy, done, aborted, valid;
    logic [23:0]   addr;
    logic [15:0]   rdata = '0;
    logic [15:0]   wdata;
    logic [1:0]    wstrb;
    logic          ready = 1'b0;
    logic          xfer_done = 1'b0;
    logic [3:0]    xfer_len;
    logic [CS-1:0] ce_ctrl;
`ifdef LISA_QSPI_DMA_FILL_EN
    logic          fill_mode = 1'b0;
    logic [15:0]   fill_data = '0;
`endif

    always #5 clk = ~clk;

    lisa_qspi_dma #(.CHIP_SELECTS(CS), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .src_ce(src_ce), .dst_ce(dst_ce),
        .word_count(word_count), .busy(busy), .done(done), .aborted(aborted),
        .addr(addr), .rdata(rdata), .wdata(wdata), .wstrb(wstrb), .ready(ready),
        .xfer_done(xfer_done), .valid(valid), .xfer_len(xfer_len),
`ifdef LISA_QSPI_DMA_FILL_EN
        .fill_mode(fill_mode), .fill_data(fill_data),
`endif
        .ce_ctrl(ce_ctrl)
    );

    typedef struct packed {
        logic [1:0]    wstrb;
        logic [CS-1:0] ce;
        logic [23:0]   addr;
        logic [3:0]    len;
    } burst_t;

    burst_t      exp_bursts[$];
    logic [15:0] exp_wdata[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          burst_cnt = 0;
    int          done_cnt = 0;
    bit          stall_req = 1'b0;

    // Memory contents as a pure function of chip select and byte address.
    function automatic logic [15:0] mem_word(input logic [CS-1:0] ce, input logic [23:0] a);
        return a[16:1] ^ {8'h3C, a[23:17], ^ce};
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_copy(input logic [23:0] s, input logic [23:0] d,
                              input logic [CS-1:0] sce, input logic [CS-1:0] dce,
                              input logic [11:0] wc, input int abort_chunk,
                              input bit fill, input logic [15:0] fdata);
        int rem;
        int chunk;
        int b;
        logic [23:0] sa;
        logic [23:0] da;
        rem = int'(wc);
        chunk = 0;
        sa = s;
        da = d;
        while (rem > 0) begin
            b = (rem > BL) ? BL : rem;
            if (!fill) exp_bursts.push_back('{2'b00, sce, sa, 4'(b)});
            exp_bursts.push_back('{2'b11, dce, da, 4'(b)});
            for (int k = 0; k < b; k++)
                exp_wdata.push_back(fill ? fdata : mem_word(sce, sa + 24'(2 * k)));
            sa = sa + 24'(2 * b);
            da = da + 24'(2 * b);
            rem = rem - b;
            if (chunk == abort_chunk) break;
            chunk++;
        end
    endtask

    always @(negedge clk) if (rst_n && done) done_cnt++;

    // QSPI slave + monitor
    initial begin
        bit          in_burst;
        bit          ending;
        bit          extra;
        int          cnt;
        int          stall;
        burst_t      cur;
        burst_t      e;
        logic [15:0] ew;
        in_burst = 0; ending = 0; extra = 0; cnt = 0; stall = 0; cur = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                in_burst = 0; ending = 0; stall = 0;
                ready = 1'b0; xfer_done = 1'b0;
                continue;
            end
            ready = 1'b0;
            xfer_done = 1'b0;
            if (ending) begin
                check(!valid, "valid_gap", valid, 0);
                ending = 0;
                in_burst = 0;
            end else if (in_burst) begin
                check(valid && addr == cur.addr, "burst_hold", {valid, addr}, {1'b1, cur.addr});
                if (stall > 0) begin
                    stall--;
                end else if (cnt < int'(cur.len)) begin
                    if (stall_req && cnt == int'(cur.len) / 2) begin
                        stall_req = 1'b0;
                        stall = 19;
                    end else if ($urandom_range(3) != 0) begin
                        ready = 1'b1;
                        rdata = mem_word(cur.ce, cur.addr + 24'(2 * cnt));
                        if (cur.wstrb == 2'b11) begin
                            if (exp_wdata.size() == 0) check(0, "wdata_extra", wdata, 0);
                            else begin
                                ew = exp_wdata.pop_front();
                                check(wdata == ew, "wdata", wdata, ew);
                            end
                        end
                        cnt++;
                        if (cnt == int'(cur.len) && $urandom_range(1) == 1) begin
                            xfer_done = 1'b1;
                            ending = 1;
                        end
                    end
                end else if (extra) begin
                    ready = 1'b1;
                    rdata = 16'($urandom);
                    extra = 0;
                end else begin
                    xfer_done = 1'b1;
                    ending = 1;
                end
            end else if (valid) begin
                cur = '{wstrb, ce_ctrl, addr, xfer_len};
                burst_cnt++;
                if (exp_bursts.size() == 0) check(0, "burst_unexpected", cur, 0);
                else begin
                    e = exp_bursts.pop_front();
                    check(cur == e, "burst", cur, e);
                end
                in_burst = 1;
                cnt = 0;
                extra = ($urandom_range(3) == 0);
            end
        end
    end

    task automatic run_copy(input logic [23:0] s, input logic [23:0] d,
                            input logic [CS-1:0] sce, input logic [CS-1:0] dce,
                            input logic [11:0] wc, input int abort_chunk,
                            input bit misuse, input bit fill, input logic [15:0] fdata);
        int base_b;
        int base_d;
        int t;
        base_b = burst_cnt;
        base_d = done_cnt;
        model_copy(s, d, sce, dce, wc, abort_chunk, fill, fdata);
        @(negedge clk);
        src_addr = s; dst_addr = d; src_ce = sce; dst_ce = dce; word_count = wc;
`ifdef LISA_QSPI_DMA_FILL_EN
        fill_mode = fill; fill_data = fdata;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        if (wc == 12'd0) check(done && !busy && !valid, "zero_count_done", {done, busy, valid}, 3'b100);
        else check(valid && busy && !done, "start_latency", {valid, busy, done}, 3'b110);
        @(negedge clk);
        start = 1'b0;
        src_addr = 24'($urandom); dst_addr = 24'($urandom);
        src_ce = CS'($urandom); dst_ce = CS'($urandom); word_count = 12'($urandom);
        if (abort_chunk >= 0) begin
            t = 0;
            while (burst_cnt < base_b + 2 * abort_chunk + 1 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check(t < 2000, "abort_wait", t, 0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        if (misuse) begin
            t = 0;
            while (burst_cnt == base_b && t < 2000) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            if (busy) begin
                word_count = 12'($urandom_range(1, 40));
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (done_cnt == base_d && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(done_cnt != base_d, "done_timeout", t, 0);
        repeat (3) @(negedge clk);
        check(done_cnt == base_d + 1, "done_once", done_cnt - base_d, 1);
        check(!busy && !valid, "idle_after", {busy, valid}, 0);
        check(aborted == (abort_chunk >= 0), "aborted_flag", aborted, abort_chunk >= 0);
        check(exp_bursts.size() == 0 && exp_wdata.size() == 0, "queues_drained",
              {exp_bursts.size(), exp_wdata.size()}, 0);
        if (wc == 12'd0) check(burst_cnt == base_b, "zero_no_bursts", burst_cnt - base_b, 0);
    endtask

    initial begin
        logic [11:0] wc;
        int          nch;
        int          ab;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check({busy, done, aborted, valid, wstrb, xfer_len, ce_ctrl} == '0 && addr == '0 && wdata == '0,
              "reset_outputs", {busy, done, aborted, valid, wstrb, xfer_len, ce_ctrl, addr, wdata}, 0);
        rst_n = 1'b1;

        run_copy(24'h000100, 24'h004000, 2'b01, 2'b10, 12'd8, -1, 0, 0, 16'h0);
        run_copy(24'h000100, 24'h004000, 2'b01, 2'b10, 12'd19, -1, 0, 0, 16'h0);
        run_copy(24'h000100, 24'h004000, 2'b01, 2'b10, 12'd0, -1, 0, 0, 16'h0);

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check(!busy && !aborted && !valid, "idle_abort_ignored", {busy, aborted, valid}, 0);
        run_copy(24'h002000, 24'h006000, 2'b10, 2'b01, 12'd12, -1, 0, 0, 16'h0);

        run_copy(24'h010000, 24'h020000, 2'b01, 2'b10, 12'd40, 1, 0, 0, 16'h0);
        run_copy(24'h010000, 24'h020000, 2'b01, 2'b10, 12'd5, -1, 0, 0, 16'h0);

        stall_req = 1'b1;
        run_copy(24'h000300, 24'h005000, 2'b01, 2'b01, 12'd8, -1, 1, 0, 16'h0);
        check(!stall_req, "stall_exercised", stall_req, 0);

        run_copy(24'h000400, 24'hFFFFF8, 2'b01, 2'b10, 12'd16, -1, 0, 0, 16'h0);

        for (int i = 0; i < 8; i++) begin
            wc = 12'($urandom_range(1, 40));
            nch = (int'(wc) + BL - 1) / BL;
            ab = (i % 3 == 1) ? int'($urandom_range(0, nch - 1)) : -1;
            run_copy(24'($urandom), 24'($urandom), CS'(1 << $urandom_range(0, 1)),
                     CS'(1 << $urandom_range(0, 1)), wc, ab, (i % 2 == 0), 0, 16'h0);
        end

        model_copy(24'h000800, 24'h009000, 2'b01, 2'b10, 12'd30, -1, 0, 16'h0);
        @(negedge clk);
        src_addr = 24'h000800; dst_addr = 24'h009000; src_ce = 2'b01; dst_ce = 2'b10; word_count = 12'd30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({busy, done, aborted, valid, wstrb, xfer_len, ce_ctrl} == '0 && addr == '0 && wdata == '0,
              "midop_reset", {busy, done, aborted, valid, wstrb, xfer_len, ce_ctrl, addr, wdata}, 0);
        repeat (2) @(negedge clk);
        exp_bursts.delete();
        exp_wdata.delete();
        rst_n = 1'b1;
        run_copy(24'h000800, 24'h009000, 2'b01, 2'b10, 12'd9, -1, 0, 0, 16'h0);

`ifdef LISA_QSPI_DMA_FILL_EN
        run_copy(24'h000000, 24'h00A000, 2'b01, 2'b10, 12'd10, -1, 0, 1, 16'hA5A5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lisa_qspi_dma.md
Name: lisa_qspi_dma

Overview:
- Block-copy engine that acts as one client of the QSPI arbiter.
- Moves word_count 16-bit words from a source chip-select/address to a destination chip-select/address.
- Each chunk is a read burst into an internal buffer, then a write burst out of it; the engine repeats chunks until the count is exhausted.
- Lets a LISA core or the debugger offload PSRAM/flash-to-PSRAM copies without per-word CPU involvement.

Parameters:
- CHIP_SELECTS, 2, width of the ce_ctrl select vectors.
- BURST_LEN, 8, maximum words per burst and buffer depth; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; launches a copy when idle
- abort  in  1  one-cycle pulse; stops the copy at the next burst boundary
- src_addr  in  24  source byte address
- dst_addr  in  24  destination byte address
- src_ce  in  CHIP_SELECTS  source chip-select vector
- dst_ce  in  CHIP_SELECTS  destination chip-select vector
- word_count  in  12  number of 16-bit words to copy
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse when the copy completes or is aborted
- aborted  out  1  sticky; set when the copy ended by abort, cleared by the next start
- addr  out  24  QSPI client address
- rdata  in  16  QSPI client read data
- wdata  out  16  QSPI client write data
- wstrb  out  2  write strobes; 2'b00 for reads
- ready  in  1  per-word handshake from the arbiter
- xfer_done  in  1  burst complete
- valid  out  1  request
- xfer_len  out  4  words in the current burst
- ce_ctrl  out  CHIP_SELECTS  chip select for the current burst

Behaviour:
- Reset: busy=0, done=0, aborted=0, valid=0, addr=0, wdata=0, wstrb=0, xfer_len=0, ce_ctrl=0; state IDLE.
- Start capture: on start in IDLE, latch src_addr, dst_addr, src_ce, dst_ce and word_count into internal registers.
  - Inputs may change after start.
  - start while busy is ignored.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start with word_count=0 goes to FIN; no QSPI traffic.
  - start with word_count≠0 sets busy and goes to RD on the next cycle.
- RD:
  - Output burst length blen = min(remaining, BURST_LEN) on xfer_len.
  - addr=cur_src, ce_ctrl=src_ce, wstrb=2'b00, valid=1.
  - Each cycle with ready=1 writes rdata into buf[wr_ptr] and increments wr_ptr.
  - ready after blen words have been captured is ignored; the buffer is never overrun.
  - When xfer_done=1, valid drops the next cycle and the state goes to WR; wr_ptr resets.
  - ready and xfer_done in the same cycle: capture the word, then transition.
- WR:
  - addr=cur_dst, ce_ctrl=dst_ce, wstrb=2'b11, xfer_len=blen, valid=1.
  - wdata=buf[rd_ptr] combinationally; rd_ptr increments on each ready.
  - When xfer_done=1:
    - cur_src += 2*blen and cur_dst += 2*blen, both mod 2^24 (wrap silently).
    - remaining -= blen.
    - If remaining=0 or an abort is pending, go to FIN; otherwise go to RD.
- valid is low for at least one cycle between bursts so the arbiter can re-arbitrate.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Abort:
  - A pulse while busy is latched.
  - An abort during RD does not cut the burst: RD completes, its WR completes, then FIN.
  - FIN following an abort sets aborted=1.
  - abort in IDLE is ignored.
- Reset mid-operation returns to IDLE immediately with all outputs at their reset values.
- Latency, start to first valid: 1 cycle.

Optional Feature:
- Macro: LISA_QSPI_DMA_FILL_EN.
- When defined, two extra inputs are added:
  - fill_mode (1), sampled at start.
  - fill_data (16).
- With fill_mode=1:
  - RD is skipped entirely.
  - WR drives wdata=fill_data for every word; blen and dst stepping are unchanged.
  - src_addr and src_ce are unused.
- When the macro is not defined, those ports do not exist and behaviour is copy-only.

Test Plan:
- Full-chunk copy (BURST_LEN=8): start with src=0x000100, dst=0x004000, word_count=8.
  - Expect one RD burst (xfer_len=8, addr=0x000100, wstrb=0).
  - Expect one WR burst (xfer_len=8, addr=0x004000, wstrb=3) writing the captured words in order.
  - Then done pulses once and busy falls.
- Partial tail, word_count=19: bursts of 8, 8 and 3.
  - Source addresses 0x000100, 0x000110, 0x000120; dst advances identically.
  - The third burst has xfer_len=3.
- Zero count, word_count=0: done pulses 1 cycle after start; valid never asserts; busy never asserts.
- Mid-burst abort: word_count=40, abort during the 2nd RD.
  - The 2nd RD and its WR complete; no 3rd RD is issued.
  - done pulses and aborted=1; a new start clears aborted.
- Stall and misuse:
  - ready held low 20 cycles mid-burst: valid stays high and addr is stable.
  - Extra ready pulses beyond blen are ignored.
  - start while busy has no effect.
  - dst=0xFFFFF8 with count 8 wraps the next dst to 0x000008.
- Fill mode (macro defined): fill_mode=1, fill_data=0xA5A5, count=10.
  - Expect only WR bursts (8, 2), all wdata=0xA5A5.
